prog_load_ctrl: RTL and testbench
=================================

Name: prog_load_ctrl

Overview:
- Controls who owns the program-memory port of the pipelined RISC-V core.
- At boot it holds the pipeline in reset and assembles a byte stream from the pins into 32-bit instruction words. It writes those words into program memory, then releases the core.
- While the core runs, the fetch stage owns the memory address. A new load request stops the core and reloads memory.

Parameters:
- ADDR_W, 5, word-address width of program memory (2^ADDR_W words).
- WORD_W, 32, instruction width; must be a multiple of 8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; when 0, FSM, counters and strobe edge detector hold state
- load_req  in  1  level; 1 = request program load
- run_req  in  1  level; 1 in IDLE starts the core without loading
- byte_in  in  8  program byte, little-endian within each word
- byte_stb  in  1  byte strobe from pin; a rising edge accepts byte_in
- fetch_addr  in  ADDR_W  word address from the fetch stage
- mem_addr  out  ADDR_W  address to program memory
- mem_wdata  out  WORD_W  write data to program memory
- mem_we  out  1  program-memory write enable, one-cycle pulse
- cpu_rst_n  out  1  pipeline reset, active low, registered
- load_done  out  1  1 in RUN after at least one completed load
- overflow  out  1  sticky; a byte was dropped because memory was full
- word_cnt  out  ADDR_W+1  number of words written by the current or last load

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0 (cpu_rst_n=0, mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, overflow=0, word_cnt=0).
  - Internal byte index=0; previous strobe value=0.
- Strobe detect: stb_q registers byte_stb every enabled cycle; an accept occurs when byte_stb=1 and stb_q=0. At most one byte per rising edge.
- States: IDLE, LOAD, FLUSH, RUN.
- IDLE:
  - cpu_rst_n=0; mem_addr=0.
  - load_req=1 → LOAD; clears word_cnt, byte index, overflow and the assembly register.
  - Else run_req=1 → RUN.
  - load_req has priority over run_req.
- LOAD:
  - cpu_rst_n=0.
  - On an accept, the byte is placed in lane byte_idx of the assembly register and byte_idx increments.
  - When byte_idx wraps from WORD_W/8-1 to 0, the next cycle drives mem_we=1, mem_addr=word_cnt[ADDR_W-1:0], mem_wdata=assembled word, and word_cnt increments. Write latency: 1 cycle after the accepting edge.
  - When word_cnt = 2^ADDR_W, further accepts are dropped and overflow is set to 1. Writes never wrap to address 0.
  - load_req=0 → FLUSH.
- FLUSH:
  - If byte_idx≠0, one write of the partial word, upper lanes zero-filled, and word_cnt increments. Skipped if full; overflow is set in that case.
  - Then → RUN. FLUSH lasts exactly 1 cycle.
- RUN:
  - cpu_rst_n=1 (registered, one cycle after entry); mem_addr=fetch_addr (combinational); mem_we=0.
  - load_done=1 if a LOAD→FLUSH path preceded this RUN.
  - load_req=1 → LOAD: cpu_rst_n drops the next cycle, word_cnt clears, overflow clears, load_done clears.
- Simultaneous events:
  - Accept in the same cycle that load_req falls: the byte is taken before FLUSH.
  - Accept on the FLUSH cycle is ignored.
- Reset mid-load: all partial state is lost and memory contents are untouched. A write in flight is aborted because mem_we is forced 0 asynchronously.
- mem_we is never asserted outside LOAD/FLUSH. mem_addr is stable during a write cycle.

Optional Feature:
- Macro LOAD_CHECKSUM_EN.
- When defined:
  - Extra output checksum[7:0], reset 0.
  - Cleared on IDLE/RUN→LOAD.
  - Holds the 8-bit modular sum of all accepted (non-dropped) bytes of the current load, updated the cycle after each accept.
  - Zero-fill bytes from FLUSH are not summed.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then run_req=1, load_req=0 → RUN within 1 cycle, cpu_rst_n=1 the next cycle, mem_addr follows fetch_addr=5'd7, load_done=0.
- load_req=1, bytes 0x13,0x00,0x50,0x00,0x93,0x00,0x10,0x00, load_req=0 → two mem_we pulses: addr0=0x00500013, addr1=0x00100093. word_cnt=2, load_done=1, cpu_rst_n=1 after FLUSH.
- Load 6 bytes 0x01..0x06 then drop load_req → writes 0x04030201 at 0 and a FLUSH write of 0x00000605 at 1; word_cnt=2.
- Load 33 words (132 bytes) with ADDR_W=5 → 32 writes (addr 0..31), overflow=1, no write to addr 0 after addr 31, word_cnt=32.
- In RUN assert load_req → cpu_rst_n=0 next cycle, load_done=0. Pull rst_n low after 2 bytes of the next word → all outputs 0 immediately and no mem_we.
- With LOAD_CHECKSUM_EN, bytes 0xFF,0x02,0x10 → checksum=0x11; after a new load starts → checksum=0x00.

Source files
------------

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl - owner of the program-memory port of the pipelined RISC-V core.
// At boot, and whenever a new load is requested, the pipeline is held in reset.
// A strobed byte stream from the pins is packed little-endian into instruction
// words, and each word is written to program memory. The core is then released,
// and the fetch stage takes over the memory address.
// Optional feature: define LOAD_CHECKSUM_EN to add port checksum[7:0]. It holds
// the 8-bit modular sum of the accepted bytes of the current load.
module prog_load_ctrl #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              load_req,
  input  logic              run_req,
  input  logic [7:0]        byte_in,
  input  logic              byte_stb,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              overflow,
`ifdef LOAD_CHECKSUM_EN
  output logic [ADDR_W:0]   word_cnt,
  output logic [7:0]        checksum
`else
  output logic [ADDR_W:0]   word_cnt
`endif
);

  localparam int LANES = WORD_W / 8;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(1) << ADDR_W;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN
  } state_t;

  state_t            r_state;
  logic              r_stb_q;
  logic [IDX_W-1:0]  r_byte_idx;
  logic [WORD_W-1:0] r_asm;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic              r_cpu_rst_n;
  logic              r_load_done;
  logic              r_overflow;

  logic              w_accept;
  logic              w_full;
  logic              w_take;
  logic              w_drop;
  logic              w_word_done;
  logic              w_partial;
  logic              w_write;
  logic [IDX_W-1:0]  w_idx_next;
  logic [WORD_W-1:0] w_asm_next;

  // Accept detection and the assembly register as it stands after this edge.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    w_accept    = byte_stb & ~r_stb_q;
    w_full      = (r_word_cnt == DEPTH);
    w_take      = ena && (r_state == S_LOAD) && w_accept && !w_full;
    w_drop      = ena && (r_state == S_LOAD) && w_accept && w_full;
    w_word_done = w_take && (r_byte_idx == LAST_LANE);
    w_asm_next  = r_asm;
    w_idx_next  = r_byte_idx;
    if (w_take) begin
      w_asm_next[r_byte_idx*8 +: 8] = byte_in;
      w_idx_next = w_word_done ? '0 : r_byte_idx + 1'b1;
    end
    // A byte taken as load_req falls still joins the word that FLUSH writes out.
    // The partial word is registered here, so its write pulse lands in the FLUSH cycle.
    w_partial = !load_req && !w_word_done && (w_idx_next != '0);
    w_write   = w_word_done || (w_partial && !w_full);
  end

  // Load/run sequencer, with the byte packer and registered memory-write outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_stb_q     <= 1'b0;
      r_byte_idx  <= '0;
      r_asm       <= '0;
      r_word_cnt  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_load_done <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      // NOTE: sequential state is updated only with non-blocking assignments.
      // mem_we is a one-cycle pulse and drops even while ena holds everything else.
      r_mem_we <= 1'b0;
      if (ena) begin
        r_stb_q <= byte_stb;
        case (r_state)
          S_IDLE, S_RUN: begin
            r_cpu_rst_n <= (r_state == S_RUN) && !load_req;
            if (load_req) begin
              r_state     <= S_LOAD;
              r_load_done <= 1'b0;
              r_overflow  <= 1'b0;
              r_word_cnt  <= '0;
              r_byte_idx  <= '0;
              r_asm       <= '0;
              r_mem_addr  <= '0;
            end else if (r_state == S_IDLE && run_req) begin
              r_state <= S_RUN;
            end
          end

          S_LOAD: begin
            r_cpu_rst_n <= 1'b0;
            if (w_drop || (w_partial && w_full)) begin
              r_overflow <= 1'b1;
            end
            if (w_write) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
              r_mem_wdata <= w_asm_next;
              r_word_cnt  <= r_word_cnt + 1'b1;
              r_asm       <= '0;
              r_byte_idx  <= '0;
            end else begin
              r_asm      <= w_asm_next;
              r_byte_idx <= w_idx_next;
            end
            if (!load_req) begin
              r_state <= S_FLUSH;
            end
          end

          S_FLUSH: begin
            r_cpu_rst_n <= 1'b0;
            r_asm       <= '0;
            r_byte_idx  <= '0;
            r_load_done <= 1'b1;
            r_state     <= S_RUN;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic       w_enter_load;
  logic [7:0] r_checksum;

  assign w_enter_load = ena && load_req && (r_state == S_IDLE || r_state == S_RUN);

  // Running byte sum of the current load. It restarts whenever a load begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_enter_load) begin
      r_checksum <= '0;
    end else if (w_take) begin
      r_checksum <= r_checksum + byte_in;
    end
  end

  assign checksum = r_checksum;
`endif

  // In RUN the fetch stage drives the address directly. Otherwise the last write address is shown.
  assign mem_addr  = (r_state == S_RUN) ? fetch_addr : r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign cpu_rst_n = r_cpu_rst_n;
  assign load_done = r_load_done;
  assign overflow  = r_overflow;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl (ADDR_W=5, WORD_W=32).
// A behavioural model tracks the load as a byte queue plus a word counter, and
// every cycle's outputs are compared against it. Literal checks pin the
// published program images and the overflow and reset cases.
module tb_prog_load_ctrl;

  localparam int ADDR_W = 5;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LANES  = WORD_W / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              load_req;
  logic              run_req;
  logic [7:0]        byte_in;
  logic              byte_stb;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_we;
  logic              cpu_rst_n;
  logic              load_done;
  logic              overflow;
  logic [ADDR_W:0]   word_cnt;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  always #5 clk = ~clk;

  prog_load_ctrl #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .load_req   (load_req),
    .run_req    (run_req),
    .byte_in    (byte_in),
    .byte_stb   (byte_stb),
    .fetch_addr (fetch_addr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .cpu_rst_n  (cpu_rst_n),
    .load_done  (load_done),
    .overflow   (overflow),
`ifdef LOAD_CHECKSUM_EN
    .word_cnt   (word_cnt),
    .checksum   (checksum)
`else
    .word_cnt   (word_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_loading, m_flushing, m_running;
  bit         m_prev_stb, m_cpu, m_done, m_ovf, m_we;
  int         m_cnt;
  int         m_waddr;
  logic [31:0] m_wdata;
  logic [7:0] m_bytes[$];
  logic [7:0] m_sum;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;
  wr_t wlog[$];

  function automatic void model_reset();
    m_loading = 0; m_flushing = 0; m_running = 0;
    m_prev_stb = 0; m_cpu = 0; m_done = 0; m_ovf = 0; m_we = 0;
    m_cnt = 0; m_waddr = 0; m_wdata = '0; m_sum = '0;
    m_bytes.delete();
  endfunction

  // Pack the queued bytes little-endian. Missing upper lanes stay zero.
  function automatic void model_emit();
    m_we    = 1;
    m_waddr = m_cnt;
    m_wdata = '0;
    foreach (m_bytes[i]) m_wdata |= 32'(m_bytes[i]) << (8 * i);
    m_cnt++;
    m_bytes.delete();
  endfunction

  // Advance the model by one clock edge, using the inputs present at that edge.
  function automatic void model_step();
    bit acc;
    m_we = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!ena) return;
    acc        = byte_stb && !m_prev_stb;
    m_prev_stb = byte_stb;
    if (m_loading) begin
      m_cpu = 0;
      if (acc) begin
        if (m_cnt == DEPTH) m_ovf = 1;
        else begin
          m_bytes.push_back(byte_in);
          m_sum += byte_in;
          if (m_bytes.size() == LANES) model_emit();
        end
      end
      if (!load_req) begin
        if (m_bytes.size() != 0) begin
          if (m_cnt == DEPTH) m_ovf = 1;
          else model_emit();
        end
        m_loading  = 0;
        m_flushing = 1;
      end
    end else if (m_flushing) begin
      m_flushing = 0; m_running = 1; m_done = 1; m_cpu = 0;
      m_bytes.delete();
    end else if (load_req) begin
      m_cpu = 0; m_running = 0; m_loading = 1; m_done = 0;
      m_cnt = 0; m_ovf = 0; m_sum = '0;
      m_bytes.delete();
    end else if (m_running) begin
      m_cpu = 1;
    end else if (run_req) begin
      m_running = 1;
    end
  endfunction

  task automatic compare();
    check("cpu_rst_n", 64'(cpu_rst_n), 64'(m_cpu));
    check("mem_we", 64'(mem_we), 64'(m_we));
    check("load_done", 64'(load_done), 64'(m_done));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("word_cnt", 64'(word_cnt), 64'(m_cnt));
    if (m_we) begin
      check("mem_addr_wr", 64'(mem_addr), 64'(m_waddr));
      check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    if (m_running) check("mem_addr_run", 64'(mem_addr), 64'(fetch_addr));
    else if (!m_loading && !m_flushing) check("mem_addr_idle", 64'(mem_addr), 64'd0);
`ifdef LOAD_CHECKSUM_EN
    check("checksum", 64'(checksum), 64'(m_sum));
`endif
  endtask

  // One clock. Inputs change only at the falling edge, after this returns.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_step();
    compare();
    if (mem_we === 1'b1) wlog.push_back('{int'(mem_addr), mem_wdata});
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in  = b;
    byte_stb = 1'b1;
    tick();
    byte_stb = 1'b0;
    tick();
  endtask

  // Assert reset between clock edges and require every output to clear at once.
  task automatic mid_reset(input string tag);
    byte_stb = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_load_done"}, 64'(load_done), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
    check({tag, "_word_cnt"}, 64'(word_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog2 [8];
    prog2 = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    rst_n = 1'b0; ena = 1'b1; load_req = 1'b0; run_req = 1'b0;
    byte_in = '0; byte_stb = 1'b0; fetch_addr = '0;
    model_reset();
    #1;
    check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_word_cnt", 64'(word_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Boot straight into RUN without loading.
    fetch_addr = 5'd7;
    run_req    = 1'b1;
    tick();
    check("run_entry_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("run_mem_addr_fetch", 64'(mem_addr), 64'd7);
    tick();
    check("run_cpu_rst_n_high", 64'(cpu_rst_n), 64'd1);
    check("run_load_done_low", 64'(load_done), 64'd0);
    run_req = 1'b0;

    // Two-word program.
    load_req = 1'b1;
    tick();
    check("reload_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    wlog.delete();
    foreach (prog2[i]) send_byte(prog2[i]);
    load_req = 1'b0;
    tick(); tick(); tick();
    check("p2_nwrites", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      check("p2_addr0", 64'(wlog[0].addr), 64'd0);
      check("p2_data0", 64'(wlog[0].data), 64'h00500013);
      check("p2_addr1", 64'(wlog[1].addr), 64'd1);
      check("p2_data1", 64'(wlog[1].data), 64'h00100093);
    end
    check("p2_word_cnt", 64'(word_cnt), 64'd2);
    check("p2_load_done", 64'(load_done), 64'd1);
    check("p2_cpu_rst_n", 64'(cpu_rst_n), 64'd1);

    // Partial last word, zero-filled by FLUSH.
    load_req = 1'b1;
    tick();
    wlog.delete();
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    load_req = 1'b0;
    tick(); tick(); tick();
    check("p3_nwrites", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      check("p3_data0", 64'(wlog[0].data), 64'h04030201);
      check("p3_addr1", 64'(wlog[1].addr), 64'd1);
      check("p3_data1", 64'(wlog[1].data), 64'h00000605);
    end
    check("p3_word_cnt", 64'(word_cnt), 64'd2);

    // 33 words into a 32-word memory.
    load_req = 1'b1;
    tick();
    wlog.delete();
    for (int i = 0; i < 132; i++) send_byte(8'(i + 1));
    load_req = 1'b0;
    tick(); tick(); tick();
    check("ovf_nwrites", 64'(wlog.size()), 64'd32);
    foreach (wlog[i]) check("ovf_addr_seq", 64'(wlog[i].addr), 64'(i));
    if (wlog.size() == 32) check("ovf_last_data", 64'(wlog[31].data), 64'h807F7E7D);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_word_cnt", 64'(word_cnt), 64'd32);

    // Reload from RUN, then reset two bytes into the second word.
    load_req = 1'b1;
    tick();
    check("rl_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("rl_load_done", 64'(load_done), 64'd0);
    check("rl_overflow", 64'(overflow), 64'd0);
    check("rl_word_cnt", 64'(word_cnt), 64'd0);
    for (int i = 0; i < 6; i++) send_byte(8'(8'hC0 + i));
    mid_reset("rst2b");

    // Reset while a write pulse is on the port.
    load_req = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) send_byte(8'(8'h30 + i));
    byte_in  = 8'hAA;
    byte_stb = 1'b1;
    tick();
    check("inflight_we_pre", 64'(mem_we), 64'd1);
    mid_reset("inflight");
    load_req = 1'b0;
    tick();

`ifdef LOAD_CHECKSUM_EN
    load_req = 1'b1;
    tick();
    send_byte(8'hFF); send_byte(8'h02); send_byte(8'h10);
    check("cks_sum", 64'(checksum), 64'h11);
    load_req = 1'b0;
    tick(); tick(); tick();
    load_req = 1'b1;
    tick();
    check("cks_clear", 64'(checksum), 64'h00);
    load_req = 1'b0;
    tick(); tick();
`endif

    // Random traffic with occasional stalls and resets.
    for (int c = 0; c < 4000; c++) begin
      ena        = ($urandom_range(0, 9) != 0);
      run_req    = 1'($urandom_range(0, 1));
      byte_stb   = 1'($urandom_range(0, 1));
      byte_in    = 8'($urandom);
      fetch_addr = ADDR_W'($urandom);
      if ($urandom_range(0, 29) == 0) load_req = ~load_req;
      rst_n = ($urandom_range(0, 999) != 0);
      tick();
    end

    // A long random load that runs past the memory size.
    rst_n    = 1'b1;
    load_req = 1'b1;
    for (int c = 0; c < 700; c++) begin
      ena        = ($urandom_range(0, 9) != 0);
      byte_stb   = 1'($urandom_range(0, 1));
      byte_in    = 8'($urandom);
      fetch_addr = ADDR_W'($urandom);
      tick();
    end
    load_req = 1'b0;
    ena      = 1'b1;
    for (int c = 0; c < 5; c++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
